pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It sits beside the forwarding logic and covers the hazards that forwarding cannot resolve:
- load-use (1-cycle bubble)
- taken branch/jump (flush of IF/ID and ID/EX)
- multi-cycle multiply/divide (front-end freeze)
- data-memory wait states (full freeze)

It drives every pipeline-register write-enable, flush and bubble control, and it keeps a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, multi-cycle mul/div front-end freeze and data-memory wait freezes.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4,
  parameter int WAIT_MAX   = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_md,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = $clog2(MD_LATENCY + 1);
  localparam int WT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  state_t           saved, saved_nxt;
  state_t           eff;
  logic [MD_W-1:0]  md_cnt, md_cnt_nxt;
  logic [WT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic             lu_done, lu_done_nxt;
  logic             mem_stall;
  logic             load_use;

  function automatic logic [WT_W-1:0] wait_inc(input logic [WT_W-1:0] v);
    return (v == WT_W'(WAIT_MAX)) ? v : v + WT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign mem_stall = dmem_req && !dmem_ready;

  // While waiting on memory, the saved state decides what happens once data arrives.
  assign eff = (state == MEM_WAIT) ? saved : state;

  // lu_done suppresses a second bubble for the same load/use pair.
  assign load_use = ex_mem_read && (ex_rt != '0) && !lu_done &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b0;
    memwb_bubble = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    state_nxt    = state;
    saved_nxt    = saved;
    md_cnt_nxt   = md_cnt;
    wait_cnt_nxt = '0;
    lu_done_nxt  = 1'b0;
    if (rst_n) begin
      md_busy = (eff == MD_BUSY);
      if (mem_stall) begin
        memwb_bubble = 1'b1;
        state_nxt    = MEM_WAIT;
        saved_nxt    = eff;
        lu_done_nxt  = lu_done;
        if (state == MEM_WAIT) begin
          wait_cnt_nxt = wait_inc(wait_cnt);
        end else begin
          wait_cnt_nxt = WT_W'(1);
        end
      end else if (eff == MD_BUSY) begin
        idex_write  = 1'b1;
        idex_bubble = 1'b1;
        exmem_write = 1'b1;
        md_cnt_nxt  = md_cnt - MD_W'(1);
        if (md_cnt == MD_W'(1)) begin
          state_nxt = RUN;
        end else begin
          state_nxt = MD_BUSY;
        end
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        state_nxt   = RUN;
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          lu_done_nxt = 1'b1;
        end else if (id_is_md) begin
          md_start   = 1'b1;
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_W'(MD_LATENCY - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      saved        <= RUN;
      md_cnt       <= '0;
      wait_cnt     <= '0;
      lu_done      <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      saved    <= saved_nxt;
      md_cnt   <= md_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      lu_done  <= lu_done_nxt;
      if (mem_stall && (wait_cnt_nxt == WT_W'(WAIT_MAX))) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write) begin
        stall_cycles <= cnt_inc(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: combinational vector table, directed multi-cycle
// sequences and random traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_md;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [9:0] exp;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_is_md, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic memwb_bubble, md_start, md_busy, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [9:0] outs;

  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                 exmem_write, memwb_bubble, md_start, md_busy, mem_timeout};

  pipeline_hazard_ctrl #(
    .REG_W(5), .MD_LATENCY(MD_LATENCY), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .md_start(md_start), .md_busy(md_busy),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int busy_cnt, mwb_cnt, cyc_idx, first_to;

  // Behavioural model: remaining mul/div freeze cycles, memory-wait run length.
  int m_md_left, m_wait_n, m_stall;
  bit m_wait, m_to, m_lu;

  localparam logic [9:0] E_IDLE = 10'b1101010000;
  localparam logic [9:0] E_LU   = 10'b0001110000;
  localparam logic [9:0] E_BR   = 10'b1111110000;
  localparam logic [9:0] E_MD   = 10'b1101010100;
  localparam logic [9:0] E_MEM  = 10'b0000001000;

  function automatic in_t mk(int rs, int rt, bit ut, bit md, bit mr, int ert,
                             bit br, bit req, bit rdy);
    in_t x;
    x.rs = 5'(rs); x.rt = 5'(rt); x.uses_rt = ut; x.is_md = md; x.mem_read = mr;
    x.ex_rt = 5'(ert); x.br = br; x.req = req; x.rdy = rdy;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.uses_rt; id_is_md = x.is_md;
    ex_mem_read = x.mem_read; ex_rt = x.ex_rt; ex_branch_taken = x.br;
    dmem_req = x.req; dmem_ready = x.rdy;
  endtask

  task automatic model_reset();
    m_md_left = 0; m_wait_n = 0; m_stall = 0; m_wait = 0; m_to = 0; m_lu = 0;
  endtask

  task automatic model_step(input in_t x, output logic [9:0] eo, output int es);
    bit pc, ifw, fl, idw, bub, exw, mwb, st, busy, to, hit;
    es = m_stall;
    to = m_to;
    busy = (m_md_left > 0);
    {pc, ifw, fl, idw, bub, exw, mwb, st} = '0;
    if (x.req && !x.rdy) begin
      mwb = 1;
      m_wait_n = m_wait ? ((m_wait_n < WAIT_MAX) ? m_wait_n + 1 : m_wait_n) : 1;
      m_wait = 1;
      if (m_wait_n == WAIT_MAX) m_to = 1;
    end else begin
      m_wait = 0;
      m_wait_n = 0;
      if (busy) begin
        idw = 1; bub = 1; exw = 1;
        m_md_left--;
        m_lu = 0;
      end else begin
        pc = 1; ifw = 1; idw = 1; exw = 1;
        hit = x.mem_read && (x.ex_rt != 0) && !m_lu &&
              ((x.ex_rt == x.rs) || (x.uses_rt && (x.ex_rt == x.rt)));
        m_lu = 0;
        if (x.br) begin
          fl = 1; bub = 1;
        end else if (hit) begin
          pc = 0; ifw = 0; bub = 1; m_lu = 1;
        end else if (x.is_md) begin
          st = 1; m_md_left = MD_LATENCY - 1;
        end
      end
    end
    eo = {pc, ifw, fl, idw, bub, exw, mwb, st, busy, to};
    if (!pc && m_stall < (1 << CNT_W) - 1) m_stall++;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input in_t x, input string nm);
    logic [9:0] eo;
    int es;
    drive(x);
    #1;
    model_step(x, eo, es);
    chk({nm, " outs"}, 32'(outs), 32'(eo));
    chk({nm, " stall_cycles"}, 32'(stall_cycles), 32'(es));
    if (md_busy) busy_cnt++;
    if (memwb_bubble) mwb_cnt++;
    if (mem_timeout && first_to < 0) first_to = cyc_idx;
    cyc_idx++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];

  initial begin
    in_t idle, md, lu5, lu0, brlu, mdbr, stall, rdy, rx;

    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    md    = mk(1, 2, 1, 1, 0, 0, 0, 0, 0);
    lu5   = mk(5, 2, 0, 0, 1, 5, 0, 0, 0);
    lu0   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0);
    brlu  = mk(5, 2, 0, 0, 1, 5, 1, 0, 0);
    mdbr  = mk(1, 2, 1, 1, 0, 0, 1, 0, 0);
    stall = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rdy   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);

    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_IDLE, "t_idle"};
    tbl[1]  = '{mk(5, 2, 0, 0, 1, 5, 0, 0, 0), E_LU,   "t_lu_rs"};
    tbl[2]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 0), E_IDLE, "t_lu_r0"};
    tbl[3]  = '{mk(3, 7, 1, 0, 1, 7, 0, 0, 0), E_LU,   "t_lu_rt"};
    tbl[4]  = '{mk(3, 7, 0, 0, 1, 7, 0, 0, 0), E_IDLE, "t_rt_unused"};
    tbl[5]  = '{mk(5, 5, 1, 0, 0, 5, 0, 0, 0), E_IDLE, "t_no_load"};
    tbl[6]  = '{mk(5, 2, 0, 0, 1, 5, 1, 0, 0), E_BR,   "t_br_lu"};
    tbl[7]  = '{mk(1, 2, 1, 1, 0, 0, 0, 0, 0), E_MD,   "t_md"};
    tbl[8]  = '{mk(4, 9, 1, 1, 1, 9, 0, 0, 0), E_LU,   "t_md_lu"};
    tbl[9]  = '{mk(1, 2, 1, 1, 0, 0, 1, 0, 0), E_BR,   "t_md_br"};
    tbl[10] = '{mk(5, 2, 0, 1, 1, 5, 1, 1, 0), E_MEM,  "t_mem_all"};
    tbl[11] = '{mk(1, 2, 1, 1, 0, 0, 0, 1, 1), E_MD,   "t_ready_md"};
    tbl[12] = '{mk(6, 6, 1, 0, 1, 7, 0, 0, 0), E_IDLE, "t_lu_miss"};

    busy_cnt = 0; mwb_cnt = 0; cyc_idx = 0; first_to = -1;

    // Outputs held at zero while in reset, whatever the inputs ask for.
    drive(brlu);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset outs", 32'(outs), 32'(0));
    chk("reset stall_cycles", 32'(stall_cycles), 32'(0));
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;

    // Clock parked low: RUN-state decode is purely combinational.
    clk_en = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].i);
      #1;
      chk(tbl[k].nm, 32'(outs), 32'(tbl[k].exp));
    end
    chk("table stall_cycles", 32'(stall_cycles), 32'(0));
    drive(idle);
    clk_en = 1'b1;
    @(negedge clk);

    // Load-use: one bubble even with the hazard held, none for r0, none under branch.
    do_reset();
    cycle(lu5, "lu_first");
    cycle(lu5, "lu_held");
    cycle(idle, "lu_after");
    chk("lu stall count", 32'(stall_cycles), 32'(1));
    cycle(lu0, "lu_r0");
    cycle(brlu, "br_lu");
    chk("br stall count", 32'(stall_cycles), 32'(1));

    // Mul/div: branches and further md requests ignored while busy.
    do_reset();
    busy_cnt = 0;
    cycle(md, "md_issue");
    repeat (3) cycle(mdbr, "md_busy");
    cycle(idle, "md_done");
    chk("md busy cycles", 32'(busy_cnt), 32'(3));
    chk("md stall count", 32'(stall_cycles), 32'(3));

    // Memory wait inside MD_BUSY.
    do_reset();
    busy_cnt = 0; mwb_cnt = 0;
    cycle(md, "mdm_issue");
    cycle(idle, "mdm_busy1");
    repeat (3) cycle(stall, "mdm_wait");
    cycle(rdy, "mdm_ready");
    repeat (2) cycle(idle, "mdm_tail");
    chk("mdm busy cycles", 32'(busy_cnt), 32'(6));
    chk("mdm bubble cycles", 32'(mwb_cnt), 32'(3));

    // Timeout during a 20-cycle wait.
    do_reset();
    cyc_idx = 0; first_to = -1;
    repeat (20) cycle(stall, "to_wait");
    cycle(rdy, "to_ready");
    cycle(idle, "to_resume");
    chk("timeout rise cycle", 32'(first_to), 32'(15));
    chk("timeout sticky", 32'(mem_timeout), 32'(1));

    // Asynchronous reset mid-MD_BUSY and mid-MEM_WAIT.
    do_reset();
    cycle(md, "ar_md_issue");
    cycle(idle, "ar_md_busy");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst md outs", 32'(outs), 32'(0));
    chk("async rst md stall_cycles", 32'(stall_cycles), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(idle, "ar_md_release");
    cycle(stall, "ar_mem_enter");
    drive(stall);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem outs", 32'(outs), 32'(0));
    chk("async rst mem stall_cycles", 32'(stall_cycles), 32'(0));
    drive(idle);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(idle, "ar_mem_release");

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      rx.rs       = 5'($urandom_range(0, 3));
      rx.rt       = 5'($urandom_range(0, 3));
      rx.uses_rt  = ($urandom_range(0, 1) == 1);
      rx.is_md    = ($urandom_range(0, 4) == 0);
      rx.mem_read = ($urandom_range(0, 2) == 0);
      rx.ex_rt    = 5'($urandom_range(0, 3));
      rx.br       = ($urandom_range(0, 7) == 0);
      rx.req      = ($urandom_range(0, 3) == 0);
      rx.rdy      = ($urandom_range(0, 1) == 0);
      cycle(rx, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
